// File: rtl/score_bitmap_writer.sv
// Four-digit BCD score keeper that redraws the 12-row score bitmap RAM once per
// frame after the score changes, one 44-pixel row per clock.
module score_bitmap_writer #(
   parameter logic [2:0]  FG_RGB   = 3'b111,
   parameter logic [2:0]  BG_RGB   = 3'b000,
   parameter int unsigned DIGIT_X0 = 12
) (
   input  logic         pclk,
   input  logic         rst_n,
   input  logic         frame_tick,
   input  logic         add_pts,
   input  logic [3:0]   pts,
   input  logic         clear_score,
   output logic         wr_en,
   output logic [3:0]   wr_addr,
   output logic [131:0] wr_data,
   output logic         busy,
   output logic [15:0]  score
);

   localparam int unsigned NUM_PIX  = 44;
   localparam logic [3:0]  LAST_ROW = 4'd11;

   typedef enum logic {
      IDLE,
      WRITE
   } state_e;

   state_e         state_q, state_d;
   logic [3:0]     row_q, row_d;
   logic [15:0]    snap_q, snap_d;
   logic [15:0]    score_q, score_d;
   logic           dirty_q, dirty_d;
   logic [131:0]   wr_data_q, wr_data_d;

   logic [15:0]    sum_bcd;
   logic           score_changed;
   logic [15:0]    rend_score;
   logic [3:0]     rend_row;
   logic [131:0]   rend_line;

   // Segment bits are {g,f,e,d,c,b,a}.
   function automatic logic [6:0] seg_map(input logic [3:0] v);
      logic [6:0] s;
      case (v)
         4'd0:    s = 7'b0111111;
         4'd1:    s = 7'b0000110;
         4'd2:    s = 7'b1011011;
         4'd3:    s = 7'b1001111;
         4'd4:    s = 7'b1100110;
         4'd5:    s = 7'b1101101;
         4'd6:    s = 7'b1111101;
         4'd7:    s = 7'b0000111;
         4'd8:    s = 7'b1111111;
         4'd9:    s = 7'b1101111;
         default: s = 7'b0000000;
      endcase
      return s;
   endfunction

   function automatic logic pix_on(input logic [6:0] seg, input int unsigned c,
                                   input int unsigned r);
      logic on;
      on = 1'b0;
      if (c != 0 && c <= 6 && r != 0 && r <= 10) begin
         on = (seg[0] && r == 1)
           || (seg[1] && c == 6 && r <= 5)
           || (seg[2] && c == 6 && r >= 5)
           || (seg[3] && r == 10)
           || (seg[4] && c == 1 && r >= 5)
           || (seg[5] && c == 1 && r <= 5)
           || (seg[6] && r == 5);
      end
      return on;
   endfunction

   function automatic logic [131:0] render(input logic [15:0] s, input logic [3:0] r);
      logic [131:0] line;
      logic [3:0]   dig;
      logic         on;
      int unsigned  rel;
      int unsigned  d;
      int unsigned  c;
      line = '0;
      for (int unsigned x = 0; x < NUM_PIX; x++) begin
         on = 1'b0;
         if (x >= DIGIT_X0) begin
            rel = x - DIGIT_X0;
            d   = rel / 8;
            c   = rel % 8;
            if (d < 4) begin
               dig = s[4*(3-d) +: 4];
               on  = pix_on(seg_map(dig), c, {28'd0, r});
            end
         end
         line[3*x +: 3] = on ? FG_RGB : BG_RGB;
      end
      return line;
   endfunction

   // Saturating BCD add of the clamped point value into the units digit.
   always_comb begin : score_next
      logic [3:0] addv;
      logic [4:0] dsum;
      logic [4:0] dwrap;
      logic       carry;
      addv    = (pts > 4'd9) ? 4'd9 : pts;
      carry   = 1'b0;
      dsum    = '0;
      dwrap   = '0;
      sum_bcd = score_q;
      for (int unsigned i = 0; i < 4; i++) begin
         dsum = {1'b0, score_q[4*i +: 4]} + ((i == 0) ? {1'b0, addv} : 5'd0)
              + {4'd0, carry};
         if (dsum > 5'd9) begin
            dwrap = dsum - 5'd10;
            sum_bcd[4*i +: 4] = dwrap[3:0];
            carry = 1'b1;
         end else begin
            sum_bcd[4*i +: 4] = dsum[3:0];
            carry = 1'b0;
         end
      end
      if (carry) begin
         sum_bcd = 16'h9999;
      end

      score_d = score_q;
      if (clear_score) begin
         score_d = '0;
      end else if (add_pts) begin
         score_d = sum_bcd;
      end
      score_changed = (score_d != score_q);
   end

   // One shared renderer: row 0 of the live score on pass start, else the next row of the snapshot.
   always_comb begin
      rend_score = (state_q == IDLE) ? score_q : snap_q;
      rend_row   = (state_q == IDLE) ? 4'd0 : row_q + 4'd1;
      rend_line  = render(rend_score, rend_row);
   end

   always_comb begin
      state_d   = state_q;
      row_d     = row_q;
      snap_d    = snap_q;
      dirty_d   = dirty_q;
      wr_data_d = wr_data_q;
      case (state_q)
         IDLE: begin
            if (frame_tick && dirty_q) begin
               state_d   = WRITE;
               snap_d    = score_q;
               row_d     = 4'd0;
               dirty_d   = 1'b0;
               wr_data_d = rend_line;
            end
         end
         WRITE: begin
            if (row_q == LAST_ROW) begin
               state_d = IDLE;
            end else begin
               row_d     = row_q + 4'd1;
               wr_data_d = rend_line;
            end
         end
         default: state_d = IDLE;
      endcase
      if (score_changed) begin
         dirty_d = 1'b1;
      end
   end

   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         row_q     <= '0;
         snap_q    <= '0;
         score_q   <= '0;
         dirty_q   <= 1'b1;
         wr_data_q <= '0;
      end else begin
         state_q   <= state_d;
         row_q     <= row_d;
         snap_q    <= snap_d;
         score_q   <= score_d;
         dirty_q   <= dirty_d;
         wr_data_q <= wr_data_d;
      end
   end

   assign wr_en   = (state_q == WRITE);
   assign busy    = (state_q == WRITE);
   assign wr_addr = row_q;
   assign wr_data = wr_data_q;
   assign score   = score_q;

endmodule

// File: tb/tb_score_bitmap_writer.sv
// Randomised bench for score_bitmap_writer against a queue-based score/bitmap model.
module tb_score_bitmap_writer;

   localparam int X0 = 12;

   logic         pclk = 1'b0;
   logic         rst_n;
   logic         frame_tick;
   logic         add_pts;
   logic [3:0]   pts;
   logic         clear_score;
   logic         wr_en;
   logic [3:0]   wr_addr;
   logic [131:0] wr_data;
   logic         busy;
   logic [15:0]  score;

   score_bitmap_writer #(
      .FG_RGB   (3'b111),
      .BG_RGB   (3'b000),
      .DIGIT_X0 (X0)
   ) dut (
      .pclk        (pclk),
      .rst_n       (rst_n),
      .frame_tick  (frame_tick),
      .add_pts     (add_pts),
      .pts         (pts),
      .clear_score (clear_score),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .busy        (busy),
      .score       (score)
   );

   always #5 pclk = ~pclk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string nm, input logic [131:0] got, input logic [131:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, got, exp, $time);
      end
   endtask

   // Glyphs as segment-letter strings; each letter is a rectangle in the 8x12 cell.
   string glyph [0:9] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg",
                          "acdfg", "acdefg", "abc", "abcdefg", "abcdfg"};
   int rc0 [0:6] = '{1, 6, 6, 1, 1, 1, 1};
   int rc1 [0:6] = '{6, 6, 6, 6, 1, 1, 6};
   int rr0 [0:6] = '{1, 1, 5, 10, 5, 1, 5};
   int rr1 [0:6] = '{1, 5, 10, 10, 10, 5, 5};

   function automatic logic [131:0] model_row(input int sc, input int r);
      logic [131:0] line;
      int dg [4];
      int d, c, idx;
      bit lit;
      string g;
      dg[0] = sc / 1000;
      dg[1] = (sc / 100) % 10;
      dg[2] = (sc / 10) % 10;
      dg[3] = sc % 10;
      line = '0;
      for (int x = X0; x < 44; x++) begin
         d = (x - X0) / 8;
         c = (x - X0) % 8;
         lit = 1'b0;
         g = glyph[dg[d]];
         for (int k = 0; k < g.len(); k++) begin
            idx = int'(g[k]) - 97;
            if (c >= rc0[idx] && c <= rc1[idx] && r >= rr0[idx] && r <= rr1[idx])
               lit = 1'b1;
         end
         if (lit) line[3*x +: 3] = 3'b111;
      end
      return line;
   endfunction

   function automatic logic [15:0] to_bcd(input int v);
      return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   // Reference model: decimal score, dirty flag, queue of pending row writes.
   int           m_score = 0;
   bit           m_dirty = 1'b1;
   bit           m_en    = 1'b0;
   int           m_addr  = 0;
   logic [131:0] m_data  = '0;
   logic [131:0] q_data [$];
   int           q_addr [$];
   int           nv;

   always @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         m_score = 0;
         m_dirty = 1'b1;
         m_en    = 1'b0;
         m_addr  = 0;
         m_data  = '0;
         q_data.delete();
         q_addr.delete();
      end else begin
         if (m_en) begin
            if (q_addr.size() > 0) begin
               m_addr = q_addr.pop_front();
               m_data = q_data.pop_front();
            end else begin
               m_en = 1'b0;
            end
         end else if (frame_tick && m_dirty) begin
            for (int r = 0; r < 12; r++) begin
               q_addr.push_back(r);
               q_data.push_back(model_row(m_score, r));
            end
            m_dirty = 1'b0;
            m_addr  = q_addr.pop_front();
            m_data  = q_data.pop_front();
            m_en    = 1'b1;
         end
         nv = m_score;
         if (clear_score) nv = 0;
         else if (add_pts) nv = m_score + ((pts > 4'd9) ? 9 : int'(pts));
         if (nv > 9999) nv = 9999;
         if (nv != m_score) m_dirty = 1'b1;
         m_score = nv;
      end
   end

   logic [131:0] cap [0:11];
   int total_writes = 0;
   int run = 0;

   always @(negedge pclk) begin
      chk("score", 132'(score), 132'(to_bcd(m_score)));
      chk("wr_en", 132'(wr_en), 132'(m_en));
      chk("busy", 132'(busy), 132'(m_en));
      if (m_en) chk("wr_addr", 132'(wr_addr), 132'(m_addr));
      chk("wr_data", wr_data, m_data);
      if (wr_en) begin
         if (wr_addr < 4'd12) cap[wr_addr] = wr_data;
         total_writes++;
      end
      if (!rst_n) run = 0;
      else if (wr_en) run++;
      else if (run != 0) begin
         chk("pass_len", 132'(run), 132'd12);
         run = 0;
      end
   end

   task automatic step();
      @(posedge pclk);
      #1;
   endtask

   task automatic idle(input int n);
      repeat (n) step();
   endtask

   task automatic do_add(input logic [3:0] p);
      add_pts = 1'b1;
      pts     = p;
      step();
      add_pts = 1'b0;
   endtask

   task automatic do_clear();
      clear_score = 1'b1;
      step();
      clear_score = 1'b0;
   endtask

   task automatic do_frame();
      frame_tick = 1'b1;
      step();
      frame_tick = 1'b0;
   endtask

   logic [131:0] lit1;
   logic [131:0] rw;
   int w0;

   initial begin
      rst_n = 1'b0;
      frame_tick = 1'b0;
      add_pts = 1'b0;
      pts = '0;
      clear_score = 1'b0;
      lit1 = '0;
      for (int d = 0; d < 4; d++)
         for (int x = 13 + 8*d; x <= 18 + 8*d; x++) lit1[3*x +: 3] = 3'b111;

      repeat (2) @(posedge pclk);
      #1;
      chk("rst_score", 132'(score), 132'h0);
      chk("rst_wr_en", 132'(wr_en), 132'h0);
      chk("rst_busy", 132'(busy), 132'h0);
      chk("rst_wr_addr", 132'(wr_addr), 132'h0);
      chk("rst_wr_data", wr_data, 132'h0);
      chk("model_row1_0000", model_row(0, 1), lit1);
      rst_n = 1'b1;
      step();

      // Initial dirty: first frame draws "0000".
      w0 = total_writes;
      do_frame();
      idle(14);
      chk("first_pass_writes", 132'(total_writes - w0), 132'd12);
      chk("first_row1", cap[1], lit1);

      // 0099 + 5 -> 0104.
      do_clear();
      repeat (11) do_add(4'd9);
      do_add(4'd5);
      chk("score_0104", 132'(score), 132'h0104);
      do_frame();
      idle(14);
      rw = cap[5];
      chk("r5_px37_42", 132'(rw[3*37 +: 18]), 132'h3FFFF);
      chk("r5_px36", 132'(rw[3*36 +: 3]), 132'h0);
      chk("r5_px43", 132'(rw[3*43 +: 3]), 132'h0);

      // Clamp and saturation.
      do_clear();
      repeat (1110) do_add(4'd9);
      do_add(4'd8);
      chk("score_9998", 132'(score), 132'h9998);
      do_frame();
      idle(14);
      do_add(4'd15);
      chk("score_sat", 132'(score), 132'h9999);
      do_frame();
      idle(14);
      w0 = total_writes;
      do_add(4'd3);
      chk("score_sat_hold", 132'(score), 132'h9999);
      do_frame();
      idle(14);
      chk("no_writes_clean", 132'(total_writes - w0), 132'd0);

      // Clear beats add.
      do_clear();
      repeat (4) do_add(4'd9);
      do_add(4'd6);
      chk("score_0042", 132'(score), 132'h0042);
      do_frame();
      idle(14);
      clear_score = 1'b1;
      add_pts = 1'b1;
      pts = 4'd7;
      step();
      clear_score = 1'b0;
      add_pts = 1'b0;
      chk("clear_wins", 132'(score), 132'h0);
      w0 = total_writes;
      do_frame();
      idle(14);
      chk("clear_dirty_writes", 132'(total_writes - w0), 132'd12);

      // Add during a pass keeps the old snapshot.
      do_add(4'd3);
      do_frame();
      idle(4);
      do_add(4'd4);
      idle(14);
      chk("midpass_old_r10", cap[10], model_row(3, 10));
      w0 = total_writes;
      do_frame();
      idle(14);
      chk("midpass_new_writes", 132'(total_writes - w0), 132'd12);
      chk("midpass_new_r10", cap[10], model_row(7, 10));

      // Reset in the middle of a pass.
      do_add(4'd1);
      do_frame();
      idle(6);
      chk("pre_rst_addr6", 132'(wr_addr), 132'd6);
      rst_n = 1'b0;
      #1;
      chk("async_rst_wr_en", 132'(wr_en), 132'h0);
      chk("async_rst_busy", 132'(busy), 132'h0);
      chk("async_rst_addr", 132'(wr_addr), 132'h0);
      step();
      step();
      rst_n = 1'b1;
      step();
      w0 = total_writes;
      do_frame();
      idle(14);
      chk("post_rst_writes", 132'(total_writes - w0), 132'd12);
      chk("post_rst_row1", cap[1], lit1);

      // Random traffic.
      for (int i = 0; i < 4000; i++) begin
         frame_tick  = ($urandom_range(0, 15) == 0);
         add_pts     = ($urandom_range(0, 3) == 0);
         pts         = 4'($urandom_range(0, 15));
         clear_score = ($urandom_range(0, 39) == 0);
         rst_n       = ($urandom_range(0, 799) != 0);
         step();
      end
      rst_n = 1'b1;
      frame_tick = 1'b0;
      add_pts = 1'b0;
      clear_score = 1'b0;
      idle(20);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
